axi4lite_fifo_slave: RTL and testbench
======================================

Name: axi4lite_fifo_slave

Overview:
AXI4-Lite responder (slave) that exposes a word-wide mailbox FIFO behind a 3-register map. It answers transactions issued by bus_ctrl or the CPU port through the smartconnect, as a peer of regmap and regbank on a smartconnect master port.
- A write to DATA pushes one word; a read from DATA pops one word.
- STATUS reports occupancy; CTRL provides a flush.

Parameters:
- ADDR_WIDTH, 32, AXI address width; only bits [7:0] are decoded.
- DATA_WIDTH, 32, AXI data width and FIFO word width.
- FIFO_DEPTH, 8, FIFO entries; a power of 2, from 2 to 128.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- s_axi_awaddr  in  ADDR_WIDTH  write address.
- s_axi_awvalid  in  1  write address valid.
- s_axi_awready  out  1  write address ready.
- s_axi_wdata  in  DATA_WIDTH  write data.
- s_axi_wstrb  in  DATA_WIDTH/8  write byte strobes.
- s_axi_wvalid  in  1  write data valid.
- s_axi_wready  out  1  write data ready.
- s_axi_bresp  out  2  write response.
- s_axi_bvalid  out  1  write response valid.
- s_axi_bready  in  1  write response ready.
- s_axi_araddr  in  ADDR_WIDTH  read address.
- s_axi_arvalid  in  1  read address valid.
- s_axi_arready  out  1  read address ready.
- s_axi_rdata  out  DATA_WIDTH  read data.
- s_axi_rresp  out  2  read response.
- s_axi_rvalid  out  1  read data valid.
- s_axi_rready  in  1  read data ready.

Behaviour:
- Reset (rst high at a clock edge):
  - awready, wready, bvalid, arready and rvalid are 0 during the reset cycle.
  - bresp, rresp and rdata reset to 0.
  - FIFO pointers and count are cleared; both holding registers are emptied.
  - Reset mid-transaction discards any pending AW, W, B or R state with no response issued.
- Register map, decoded on addr[7:0]:
  - 0x00 DATA.
  - 0x04 STATUS, read-only: [0] empty, [1] full, [15:8] count, other bits 0.
  - 0x08 CTRL: write bit0=1 flushes the FIFO (self-clearing); reads return 0.
  - Any other offset returns DECERR (2'b11) and has no side effect.
- Write channel:
  - awready is 1 when the AW holding register is empty and bvalid=0.
  - wready is 1 when the W holding register is empty and bvalid=0.
  - AW and W are accepted independently, in any order and in any cycle gap.
  - When both holding registers are full, the write executes; bvalid rises the next cycle. Same-cycle AW+W handshake at cycle N gives bvalid at N+1.
  - bvalid and bresp hold until bready; both holding registers clear on the B handshake.
- Write to DATA:
  - Pushes only if wstrb is all ones and the FIFO is not full → OKAY.
  - Full FIFO or partial strobe → SLVERR, no push, FIFO unchanged.
- Write to STATUS → SLVERR, ignored.
- Write to CTRL → OKAY, regardless of wstrb.
- Read channel:
  - arready = !rvalid, so one read is outstanding at a time.
  - AR handshake at cycle N gives rvalid at N+1 with rdata and rresp registered.
  - rdata, rresp and rvalid hold until rready.
- Read from DATA:
  - Non-empty FIFO → head word, OKAY, pop at the AR handshake.
  - Empty FIFO → rdata=0, SLVERR, no pop.
- STATUS reads reflect state before any same-cycle push, pop or flush.
- Simultaneous events, all judged on pre-cycle occupancy:
  - Push and pop in the same cycle: both are judged on pre-cycle occupancy; count is unchanged when both succeed.
  - Empty FIFO with same-cycle push: the read gets SLVERR and the push succeeds.
  - Full FIFO with same-cycle pop: the write gets SLVERR and the pop succeeds.
  - Flush with same-cycle pop: the read returns the pre-flush head with OKAY, then pointers are cleared. Flush has priority over the pointer updates.
- Pointers:
  - log2(FIFO_DEPTH) bits, wrapping modulo FIFO_DEPTH.
  - count is log2(FIFO_DEPTH)+1 bits, range 0..FIFO_DEPTH, zero-extended into STATUS[15:8].
- Fixed outputs: bresp and rresp are never 2'b01 (EXOKAY).

Test Plan:
1. Reset, then read 0x04 → rdata=0x0000_0001 (empty, count 0), OKAY. Read 0x00 → rdata=0, rresp=SLVERR.
2. Write 0x00 with 0xA5A5_0001, 0xA5A5_0002, 0xA5A5_0003 (wstrb=0xF), same-cycle AW/W → each bvalid one cycle later, OKAY. Read 0x04 → count 3. Three reads of 0x00 → 0xA5A5_0001, 0xA5A5_0002, 0xA5A5_0003 in order, OKAY.
3. Fill 8 words; 9th write → SLVERR and STATUS=0x0000_0802. Pop 8 words to check wrap; then write/read 4 more words → correct data after pointer wrap.
4. Ordering and backpressure:
   - Issue W 3 cycles before AW → bvalid exactly 1 cycle after the AW handshake.
   - Hold bready=0 for 5 cycles → bvalid and bresp stable, awready=wready=0.
   - Hold rready=0 → arready stays 0.
5. Write 0x0C → DECERR. Write 0x00 with wstrb=0x3 → SLVERR, count unchanged. Write 0x08 with 0x1 while count=5 → STATUS count 0 afterwards.
6. Special cases:
   - Count=1: pop and push in the same cycle → read OKAY with the old word, count stays 1.
   - Assert rst while bvalid is pending → bvalid=0 next cycle and FIFO empty.

Source files
------------

// File: rtl/axi4lite_fifo_slave.sv
// AXI4-Lite responder fronting a word-wide mailbox FIFO: DATA push/pop, STATUS occupancy, CTRL flush.
// B follows one cycle after AW and W are both held; R follows one cycle after the AR handshake.
module axi4lite_fifo_slave #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int STRB_W = DATA_WIDTH / 8;

    localparam logic [7:0] ADDR_DATA   = 8'h00;
    localparam logic [7:0] ADDR_STATUS = 8'h04;
    localparam logic [7:0] ADDR_CTRL   = 8'h08;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    logic                  aw_full_q, aw_full_d;
    logic [7:0]            aw_addr_q, aw_addr_d;
    logic                  w_full_q, w_full_d;
    logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
    logic [STRB_W-1:0]     w_strb_q, w_strb_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  rvalid_q, rvalid_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];

    logic                  aw_hs, w_hs, ar_hs, wr_exec;
    logic [7:0]            wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [STRB_W-1:0]     wr_strb;
    logic                  fifo_empty, fifo_full;
    logic                  push, pop, flush;
    logic [DATA_WIDTH-1:0] status;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{s_axi_awaddr[ADDR_WIDTH-1:8], s_axi_araddr[ADDR_WIDTH-1:8]};

    assign s_axi_awready = !rst && !aw_full_q && !bvalid_q;
    assign s_axi_wready  = !rst && !w_full_q && !bvalid_q;
    assign s_axi_arready = !rst && !rvalid_q;
    assign s_axi_bvalid  = !rst && bvalid_q;
    assign s_axi_rvalid  = !rst && rvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rdata   = rdata_q;

    assign aw_hs = s_axi_awvalid && s_axi_awready;
    assign w_hs  = s_axi_wvalid && s_axi_wready;
    assign ar_hs = s_axi_arvalid && s_axi_arready;

    // The write executes in the cycle the second half arrives, so bypass the holding registers.
    assign wr_addr = aw_full_q ? aw_addr_q : s_axi_awaddr[7:0];
    assign wr_data = w_full_q ? w_data_q : s_axi_wdata;
    assign wr_strb = w_full_q ? w_strb_q : s_axi_wstrb;
    assign wr_exec = !rst && !bvalid_q && (aw_full_q || aw_hs) && (w_full_q || w_hs);

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));

    always_comb begin
        status           = '0;
        status[0]        = fifo_empty;
        status[1]        = fifo_full;
        status[8 +: CNT_W] = count_q;
    end

    always_comb begin
        aw_full_d = aw_full_q;
        aw_addr_d = aw_addr_q;
        w_full_d  = w_full_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        push      = 1'b0;
        flush     = 1'b0;

        if (aw_hs) begin
            aw_full_d = 1'b1;
            aw_addr_d = s_axi_awaddr[7:0];
        end
        if (w_hs) begin
            w_full_d = 1'b1;
            w_data_d = s_axi_wdata;
            w_strb_d = s_axi_wstrb;
        end

        if (wr_exec) begin
            bvalid_d = 1'b1;
            case (wr_addr)
                ADDR_DATA: begin
                    if (&wr_strb && !fifo_full) begin
                        push    = 1'b1;
                        bresp_d = RESP_OKAY;
                    end else begin
                        bresp_d = RESP_SLVERR;
                    end
                end
                ADDR_STATUS: bresp_d = RESP_SLVERR;
                ADDR_CTRL: begin
                    bresp_d = RESP_OKAY;
                    flush   = wr_data[0];
                end
                default: bresp_d = RESP_DECERR;
            endcase
        end else if (bvalid_q && s_axi_bready) begin
            bvalid_d  = 1'b0;
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
        end
    end

    always_comb begin
        rvalid_d = rvalid_q;
        rresp_d  = rresp_q;
        rdata_d  = rdata_q;
        pop      = 1'b0;

        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = '0;
            case (s_axi_araddr[7:0])
                ADDR_DATA: begin
                    if (!fifo_empty) begin
                        rdata_d = mem_q[rd_ptr_q];
                        rresp_d = RESP_OKAY;
                        pop     = 1'b1;
                    end else begin
                        rresp_d = RESP_SLVERR;
                    end
                end
                ADDR_STATUS: begin
                    rdata_d = status;
                    rresp_d = RESP_OKAY;
                end
                ADDR_CTRL: rresp_d = RESP_OKAY;
                default:   rresp_d = RESP_DECERR;
            endcase
        end else if (rvalid_q && s_axi_rready) begin
            rvalid_d = 1'b0;
        end
    end

    // Push and pop are both judged on pre-cycle occupancy; flush overrides the pointer updates.
    always_comb begin
        mem_d    = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = wr_data;
        end
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            aw_full_q <= 1'b0;
            aw_addr_q <= '0;
            w_full_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= '0;
            rvalid_q  <= 1'b0;
            rresp_q   <= '0;
            rdata_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            aw_full_q <= aw_full_d;
            aw_addr_q <= aw_addr_d;
            w_full_q  <= w_full_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: tb/tb_axi4lite_fifo_slave.sv
// Directed bench for axi4lite_fifo_slave: register-map vector table plus multi-cycle corner sequences.
module tb_axi4lite_fifo_slave;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b1;
    logic [31:0] araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b1;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    axi4lite_fifo_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst(rst),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready)
    );

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             output logic [1:0] resp, output int lat);
        bit aw_done, w_done;
        int guard;
        aw_done = 0; w_done = 0; guard = 0; lat = 0;
        @(negedge clk);
        awaddr = {24'h0, addr}; awvalid = 1'b1;
        wdata = data; wstrb = strb; wvalid = 1'b1; bready = 1'b1;
        while (!(aw_done && w_done) && guard < 50) begin
            if (awvalid && awready) aw_done = 1;
            if (wvalid && wready) w_done = 1;
            @(negedge clk);
            if (aw_done) awvalid = 1'b0;
            if (w_done) wvalid = 1'b0;
            guard++;
        end
        while (!bvalid && guard < 100) begin
            @(negedge clk);
            lat++; guard++;
        end
        if (guard >= 100 || !(aw_done && w_done)) lat = -1;
        awvalid = 1'b0; wvalid = 1'b0;
        resp = bresp;
        @(negedge clk);
    endtask

    task automatic axi_read(input logic [7:0] addr, output logic [1:0] resp, output logic [31:0] data,
                            output int lat);
        int guard;
        guard = 0; lat = 0;
        @(negedge clk);
        araddr = {24'h0, addr}; arvalid = 1'b1; rready = 1'b1;
        while (!arready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        arvalid = 1'b0;
        while (!rvalid && guard < 100) begin
            @(negedge clk);
            lat++; guard++;
        end
        if (guard >= 50) lat = -1;
        resp = rresp; data = rdata;
        @(negedge clk);
    endtask

    // AW, W and AR all presented in the same cycle against an idle slave.
    task automatic concurrent(input logic [7:0] waddr, input logic [31:0] wd, input logic [7:0] raddr,
                              output logic [1:0] br, output logic [1:0] rr, output logic [31:0] rd,
                              output bit ok);
        @(negedge clk);
        ok = awready && wready && arready;
        awaddr = {24'h0, waddr}; awvalid = 1'b1; wdata = wd; wstrb = 4'hF; wvalid = 1'b1;
        araddr = {24'h0, raddr}; arvalid = 1'b1; bready = 1'b0; rready = 1'b0;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        ok = ok && bvalid && rvalid;
        br = bresp; rr = rresp; rd = rdata;
        bready = 1'b1; rready = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  resp, br, rr;
        logic [31:0] data, rd, held;
        int          lat;
        bit          ok;

        vecs[0]  = '{1'b0, 8'h04, 32'h0,         4'h0, OKAY,   32'h0000_0001};
        vecs[1]  = '{1'b0, 8'h00, 32'h0,         4'h0, SLVERR, 32'h0};
        vecs[2]  = '{1'b1, 8'h00, 32'hA5A5_0001, 4'hF, OKAY,   32'h0};
        vecs[3]  = '{1'b1, 8'h00, 32'hA5A5_0002, 4'hF, OKAY,   32'h0};
        vecs[4]  = '{1'b1, 8'h00, 32'hA5A5_0003, 4'hF, OKAY,   32'h0};
        vecs[5]  = '{1'b0, 8'h04, 32'h0,         4'h0, OKAY,   32'h0000_0300};
        vecs[6]  = '{1'b0, 8'h00, 32'h0,         4'h0, OKAY,   32'hA5A5_0001};
        vecs[7]  = '{1'b0, 8'h00, 32'h0,         4'h0, OKAY,   32'hA5A5_0002};
        vecs[8]  = '{1'b0, 8'h00, 32'h0,         4'h0, OKAY,   32'hA5A5_0003};
        vecs[9]  = '{1'b0, 8'h04, 32'h0,         4'h0, OKAY,   32'h0000_0001};
        vecs[10] = '{1'b1, 8'h0C, 32'h1234_5678, 4'hF, DECERR, 32'h0};
        vecs[11] = '{1'b0, 8'h0C, 32'h0,         4'h0, DECERR, 32'h0};
        vecs[12] = '{1'b1, 8'h00, 32'hBEEF_0000, 4'h3, SLVERR, 32'h0};
        vecs[13] = '{1'b0, 8'h04, 32'h0,         4'h0, OKAY,   32'h0000_0001};
        vecs[14] = '{1'b1, 8'h04, 32'hFFFF_FFFF, 4'hF, SLVERR, 32'h0};
        vecs[15] = '{1'b0, 8'h08, 32'h0,         4'h0, OKAY,   32'h0};

        // Reset state
        @(negedge clk);
        check("rst_awready", {31'h0, awready}, 32'h0);
        check("rst_wready",  {31'h0, wready},  32'h0);
        check("rst_arready", {31'h0, arready}, 32'h0);
        check("rst_bvalid",  {31'h0, bvalid},  32'h0);
        check("rst_rvalid",  {31'h0, rvalid},  32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_bresp", {30'h0, bresp}, 32'h0);
        check("rst_rresp", {30'h0, rresp}, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("idle_awready", {31'h0, awready}, 32'h1);

        for (int i = 0; i < 16; i++) begin
            if (vecs[i].wr) begin
                axi_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb, resp, lat);
                check($sformatf("vec%0d_bresp", i), {30'h0, resp}, {30'h0, vecs[i].exp_resp});
                check($sformatf("vec%0d_blat", i), lat, 0);
            end else begin
                axi_read(vecs[i].addr, resp, data, lat);
                check($sformatf("vec%0d_rresp", i), {30'h0, resp}, {30'h0, vecs[i].exp_resp});
                check($sformatf("vec%0d_rdata", i), data, vecs[i].exp_rdata);
                check($sformatf("vec%0d_rlat", i), lat, 0);
            end
        end

        // Fill to full (pointers start at 3, so this wraps), overflow, drain, refill.
        for (int i = 0; i < 8; i++) begin
            axi_write(8'h00, 32'h1000_0000 + i, 4'hF, resp, lat);
            check($sformatf("fill%0d_bresp", i), {30'h0, resp}, {30'h0, OKAY});
        end
        axi_write(8'h00, 32'h1000_0008, 4'hF, resp, lat);
        check("overflow_bresp", {30'h0, resp}, {30'h0, SLVERR});
        axi_read(8'h04, resp, data, lat);
        check("full_status", data, 32'h0000_0802);
        for (int i = 0; i < 8; i++) begin
            axi_read(8'h00, resp, data, lat);
            check($sformatf("drain%0d_rdata", i), data, 32'h1000_0000 + i);
        end
        for (int i = 0; i < 4; i++) begin
            axi_write(8'h00, 32'h2000_0000 + i, 4'hF, resp, lat);
            check($sformatf("wrap_w%0d_bresp", i), {30'h0, resp}, {30'h0, OKAY});
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(8'h00, resp, data, lat);
            check($sformatf("wrap_r%0d_rdata", i), data, 32'h2000_0000 + i);
            check($sformatf("wrap_r%0d_rresp", i), {30'h0, resp}, {30'h0, OKAY});
        end

        // W three cycles ahead of AW, then B backpressure.
        @(negedge clk);
        bready = 1'b0;
        wdata = 32'hC0DE_0001; wstrb = 4'hF; wvalid = 1'b1;
        check("early_w_wready", {31'h0, wready}, 32'h1);
        @(negedge clk);
        wvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("early_w_nob%0d", i), {31'h0, bvalid}, 32'h0);
            @(negedge clk);
        end
        check("early_w_wready_held", {31'h0, wready}, 32'h0);
        awaddr = 32'h0; awvalid = 1'b1;
        check("late_aw_awready", {31'h0, awready}, 32'h1);
        @(negedge clk);
        awvalid = 1'b0;
        check("late_aw_bvalid", {31'h0, bvalid}, 32'h1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("bp%0d_bvalid", i), {31'h0, bvalid}, 32'h1);
            check($sformatf("bp%0d_bresp", i), {30'h0, bresp}, {30'h0, OKAY});
            check($sformatf("bp%0d_awready", i), {31'h0, awready}, 32'h0);
            check($sformatf("bp%0d_wready", i), {31'h0, wready}, 32'h0);
        end
        bready = 1'b1;
        @(negedge clk);
        check("bp_release_bvalid", {31'h0, bvalid}, 32'h0);

        // R backpressure.
        rready = 1'b0;
        araddr = 32'h0; arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        check("rbp_rvalid", {31'h0, rvalid}, 32'h1);
        check("rbp_rdata", rdata, 32'hC0DE_0001);
        held = rdata;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("rbp%0d_arready", i), {31'h0, arready}, 32'h0);
            check($sformatf("rbp%0d_rdata", i), rdata, held);
        end
        rready = 1'b1;
        @(negedge clk);
        check("rbp_release_rvalid", {31'h0, rvalid}, 32'h0);

        // Flush with five entries.
        for (int i = 0; i < 5; i++) axi_write(8'h00, 32'h5000_0000 + i, 4'hF, resp, lat);
        axi_read(8'h04, resp, data, lat);
        check("pre_flush_status", data, 32'h0000_0500);
        axi_write(8'h08, 32'h1, 4'hF, resp, lat);
        check("flush_bresp", {30'h0, resp}, {30'h0, OKAY});
        axi_read(8'h04, resp, data, lat);
        check("post_flush_status", data, 32'h0000_0001);

        // Count 1: same-cycle push and pop.
        axi_write(8'h00, 32'h3000_0001, 4'hF, resp, lat);
        concurrent(8'h00, 32'h3000_0002, 8'h00, br, rr, rd, ok);
        check("pp_handshake", {31'h0, ok}, 32'h1);
        check("pp_bresp", {30'h0, br}, {30'h0, OKAY});
        check("pp_rresp", {30'h0, rr}, {30'h0, OKAY});
        check("pp_rdata", rd, 32'h3000_0001);
        axi_read(8'h04, resp, data, lat);
        check("pp_status", data, 32'h0000_0100);
        axi_read(8'h00, resp, data, lat);
        check("pp_new_head", data, 32'h3000_0002);

        // Empty FIFO with same-cycle push.
        concurrent(8'h00, 32'h3000_0003, 8'h00, br, rr, rd, ok);
        check("ep_bresp", {30'h0, br}, {30'h0, OKAY});
        check("ep_rresp", {30'h0, rr}, {30'h0, SLVERR});
        check("ep_rdata", rd, 32'h0);
        axi_read(8'h04, resp, data, lat);
        check("ep_status", data, 32'h0000_0100);

        // Full FIFO with same-cycle pop.
        for (int i = 0; i < 7; i++) axi_write(8'h00, 32'h4000_0000 + i, 4'hF, resp, lat);
        concurrent(8'h00, 32'hDEAD_BEEF, 8'h00, br, rr, rd, ok);
        check("fp_bresp", {30'h0, br}, {30'h0, SLVERR});
        check("fp_rresp", {30'h0, rr}, {30'h0, OKAY});
        check("fp_rdata", rd, 32'h3000_0003);
        axi_read(8'h04, resp, data, lat);
        check("fp_status", data, 32'h0000_0700);

        // Flush with same-cycle pop.
        concurrent(8'h08, 32'h1, 8'h00, br, rr, rd, ok);
        check("fpop_bresp", {30'h0, br}, {30'h0, OKAY});
        check("fpop_rresp", {30'h0, rr}, {30'h0, OKAY});
        check("fpop_rdata", rd, 32'h4000_0000);
        axi_read(8'h04, resp, data, lat);
        check("fpop_status", data, 32'h0000_0001);

        // Reset while a write response is pending.
        @(negedge clk);
        bready = 1'b0;
        awaddr = 32'h0; awvalid = 1'b1; wdata = 32'h7777_0001; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        check("rstb_bvalid_pending", {31'h0, bvalid}, 32'h1);
        rst = 1'b1;
        #1;
        check("rstb_awready", {31'h0, awready}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        bready = 1'b1;
        #1;
        check("rstb_bvalid_cleared", {31'h0, bvalid}, 32'h0);
        axi_read(8'h04, resp, data, lat);
        check("rstb_status", data, 32'h0000_0001);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
